// File: rtl/activation_mem_ctrl.sv
// activation_mem_ctrl: loads one activation tile into memory, then streams it row by row to the systolic array.
module activation_mem_ctrl #(
  parameter int SIZE             = 8,
  parameter int MEM_SIZE         = SIZE * SIZE,
  parameter int WRITE_ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int READ_ADDR_WIDTH  = $clog2(SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [6:0]                  act_in,
  input  logic                        act_valid,
  output logic                        act_ready,
  input  logic                        compute_start,
  input  logic                        reuse,
  output logic [6:0]                  Activation,
  output logic [WRITE_ADDR_WIDTH-1:0] Wr_Addr,
  output logic                        Wr_en,
  output logic                        Rd_en,
  output logic [READ_ADDR_WIDTH-1:0]  Rd_Addr,
  output logic                        row_valid,
  output logic [READ_ADDR_WIDTH-1:0]  row_idx,
  output logic                        load_done,
  output logic                        compute_done
);
  typedef enum logic [1:0] {LOAD, FULL, READ, DRAIN} state_t;
  state_t                      r_state;
  logic [WRITE_ADDR_WIDTH-1:0] r_wcnt;
  logic                        w_accept;
  logic                        w_last_wr;
  logic                        w_last_rd;
  assign act_ready = (r_state == LOAD) && !rst;
  assign w_accept  = act_valid && act_ready;
  assign w_last_wr = r_wcnt == WRITE_ADDR_WIDTH'(MEM_SIZE - 1);
  assign w_last_rd = Rd_Addr == READ_ADDR_WIDTH'(SIZE - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_wcnt       <= '0;
      Activation   <= '0;
      Wr_Addr      <= '0;
      Wr_en        <= 1'b0;
      Rd_en        <= 1'b0;
      Rd_Addr      <= '0;
      row_valid    <= 1'b0;
      row_idx      <= '0;
      load_done    <= 1'b0;
      compute_done <= 1'b0;
    end else begin
      Wr_en        <= 1'b0;
      Rd_en        <= 1'b0;
      row_valid    <= 1'b0;
      load_done    <= 1'b0;
      compute_done <= 1'b0;
      case (r_state)
        LOAD: if (w_accept) begin
          Wr_en      <= 1'b1;
          Activation <= act_in;
          Wr_Addr    <= r_wcnt;
          r_wcnt     <= w_last_wr ? '0 : r_wcnt + 1'b1;
          if (w_last_wr) begin
            load_done <= 1'b1;
            r_state   <= FULL;
          end
        end
        FULL: if (compute_start) begin
          r_state <= READ;
          Rd_en   <= 1'b1;
          Rd_Addr <= '0;
        end
        // Rd_Addr doubles as the row counter; row_valid trails each read by one cycle
        READ: begin
          row_valid <= 1'b1;
          row_idx   <= Rd_Addr;
          if (w_last_rd) begin
            compute_done <= 1'b1;
            r_state      <= DRAIN;
          end else begin
            Rd_en   <= 1'b1;
            Rd_Addr <= Rd_Addr + 1'b1;
          end
        end
        DRAIN: begin
          r_state <= reuse ? FULL : LOAD;
          if (!reuse) r_wcnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_activation_mem_ctrl.sv
// tb_activation_mem_ctrl: randomized scenario checks against an accept-count model of the tile load/stream protocol.
module tb_activation_mem_ctrl;
  localparam int SIZE = 8;
  localparam int MEM = SIZE * SIZE;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] act_in = '0;
  logic       act_valid = 1'b0;
  logic       act_ready;
  logic       compute_start = 1'b0;
  logic       reuse = 1'b0;
  logic [6:0] Activation;
  logic [5:0] Wr_Addr;
  logic       Wr_en;
  logic       Rd_en;
  logic [2:0] Rd_Addr;
  logic       row_valid;
  logic [2:0] row_idx;
  logic       load_done;
  logic       compute_done;
  int n_cmp = 0;
  int n_err = 0;
  int exp_waddr = 0;
  int exp_raddr = 0;
  activation_mem_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
    .compute_start(compute_start), .reuse(reuse), .Activation(Activation), .Wr_Addr(Wr_Addr),
    .Wr_en(Wr_en), .Rd_en(Rd_en), .Rd_Addr(Rd_Addr), .row_valid(row_valid), .row_idx(row_idx),
    .load_done(load_done), .compute_done(compute_done)
  );
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({Wr_en, Rd_en, row_valid, load_done, compute_done, act_ready} !== 6'b0 ||
        Activation !== 7'd0 || Wr_Addr !== 6'd0 || Rd_Addr !== 3'd0 || row_idx !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: strobes=%b act=%0d wa=%0d ra=%0d ri=%0d, want all 0",
               {Wr_en, Rd_en, row_valid, load_done, compute_done, act_ready}, Activation, Wr_Addr, Rd_Addr, row_idx);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (act_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: act_ready=%b want 1", act_ready); end
    exp_waddr = 0;
    exp_raddr = 0;
  endtask
  // mode 0: valid every cycle, 1: every other cycle, 2: random; seq selects data=k
  task automatic load_tile(input int mode, input bit seq, input int start_at);
    int k = 0;
    int cyc = 0;
    logic v;
    logic [6:0] d;
    while (k < MEM && cyc < 2000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom % 2);
      d = seq ? 7'(k) : 7'($urandom);
      act_valid = v;
      act_in = d;
      compute_start = (cyc == start_at);
      n_cmp++;
      if (act_ready !== 1'b1) begin n_err++; $display("FAIL load_ready: k=%0d act_ready=%b want 1", k, act_ready); end
      tick;
      if (v) exp_waddr = k;
      n_cmp++;
      if (Wr_en !== v || Wr_Addr !== 6'(exp_waddr) || (v && Activation !== d) ||
          load_done !== (v && k == MEM - 1) || Rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL load_write: k=%0d got en=%b wa=%0d act=%0d ld=%b rd=%b want en=%b wa=%0d act=%0d ld=%b rd=0",
                 k, Wr_en, Wr_Addr, Activation, load_done, Rd_en, v, exp_waddr, d, v && k == MEM - 1);
      end
      if (v) k++;
      cyc++;
    end
    compute_start = 1'b0;
    if (k < MEM) begin n_err++; $display("FAIL load_bound: only %0d accepts in %0d cycles", k, cyc); end
    act_valid = 1'b1;
    #1;
    n_cmp++;
    if (act_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: act_ready=%b want 0", act_ready); end
    tick;
    act_valid = 1'b0;
    n_cmp++;
    if (Wr_en !== 1'b0 || load_done !== 1'b0) begin
      n_err++; $display("FAIL full_no_write: Wr_en=%b load_done=%b want 0 0", Wr_en, load_done);
    end
  endtask
  task automatic idle_full(input int n);
    for (int i = 0; i < n; i++) begin
      act_valid = 1'($urandom % 2);
      tick;
      n_cmp++;
      if (Rd_en !== 1'b0 || Wr_en !== 1'b0 || act_ready !== 1'b0 || row_valid !== 1'b0 || Rd_Addr !== 3'(exp_raddr)) begin
        n_err++;
        $display("FAIL full_idle: rd=%b wr=%b rdy=%b rv=%b ra=%0d want 0 0 0 0 %0d", Rd_en, Wr_en, act_ready, row_valid, Rd_Addr, exp_raddr);
      end
    end
    act_valid = 1'b0;
  endtask
  task automatic read_pass(input logic reuse_v);
    compute_start = 1'b1;
    tick;
    compute_start = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      act_valid = 1'($urandom % 2);
      n_cmp++;
      if (Rd_en !== 1'b1 || Rd_Addr !== 3'(i) || row_valid !== (i != 0) || (i != 0 && row_idx !== 3'(i - 1)) ||
          Wr_en !== 1'b0 || compute_done !== 1'b0 || act_ready !== 1'b0) begin
        n_err++;
        $display("FAIL read_row: i=%0d got rd=%b ra=%0d rv=%b ri=%0d wr=%b cd=%b rdy=%b want rd=1 ra=%0d rv=%b ri=%0d wr=0 cd=0 rdy=0",
                 i, Rd_en, Rd_Addr, row_valid, row_idx, Wr_en, compute_done, act_ready, i, i != 0, i - 1);
      end
      tick;
    end
    act_valid = 1'b0;
    exp_raddr = SIZE - 1;
    n_cmp++;
    if (Rd_en !== 1'b0 || Rd_Addr !== 3'(SIZE - 1) || row_valid !== 1'b1 || row_idx !== 3'(SIZE - 1) ||
        compute_done !== 1'b1 || Wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got rd=%b ra=%0d rv=%b ri=%0d cd=%b wr=%b want 0 7 1 7 1 0", Rd_en, Rd_Addr, row_valid, row_idx, compute_done, Wr_en);
    end
    reuse = reuse_v;
    tick;
    reuse = 1'b0;
    n_cmp++;
    if (compute_done !== 1'b0 || row_valid !== 1'b0 || Rd_en !== 1'b0 || act_ready !== !reuse_v) begin
      n_err++;
      $display("FAIL after_drain: reuse=%b got cd=%b rv=%b rd=%b rdy=%b want 0 0 0 %b", reuse_v, compute_done, row_valid, Rd_en, act_ready, !reuse_v);
    end
  endtask
  task automatic test_back_to_back;
    load_tile(0, 1'b1, -1);
    idle_full(2);
    read_pass(1'b1);
    idle_full(3);
    read_pass(1'b0);
  endtask
  task automatic test_toggle;
    load_tile(1, 1'b0, -1);
    read_pass(1'b0);
  endtask
  task automatic test_ignored_start;
    load_tile(2, 1'b0, 10);
    idle_full(6);
    read_pass(1'b0);
  endtask
  task automatic test_reset_mid_read;
    load_tile(2, 1'b0, -1);
    compute_start = 1'b1;
    tick;
    compute_start = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    n_cmp++;
    if (Rd_Addr !== 3'd3 || Rd_en !== 1'b1) begin n_err++; $display("FAIL pre_reset_read: ra=%0d rd=%b want 3 1", Rd_Addr, Rd_en); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({Wr_en, Rd_en, row_valid, load_done, compute_done} !== 5'b0 || act_ready !== 1'b1 ||
        Wr_Addr !== 6'd0 || Rd_Addr !== 3'd0 || row_idx !== 3'd0) begin
      n_err++;
      $display("FAIL mid_read_reset: strobes=%b rdy=%b wa=%0d ra=%0d ri=%0d want 0 1 0 0 0",
               {Wr_en, Rd_en, row_valid, load_done, compute_done}, act_ready, Wr_Addr, Rd_Addr, row_idx);
    end
    exp_waddr = 0;
    exp_raddr = 0;
    load_tile(0, 1'b0, -1);
    read_pass(1'b1);
    read_pass(1'b0);
  endtask
  task automatic test_reset_mid_load;
    act_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin act_in = 7'($urandom); tick; end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    act_valid = 1'b0;
    #1;
    n_cmp++;
    if (Wr_en !== 1'b0 || Wr_Addr !== 6'd0 || act_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_load_reset: wr=%b wa=%0d rdy=%b want 0 0 1", Wr_en, Wr_Addr, act_ready);
    end
    exp_waddr = 0;
    load_tile(2, 1'b0, -1);
    read_pass(1'b0);
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_toggle;
    test_ignored_start;
    test_reset_mid_read;
    test_reset_mid_load;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
